acc_input_fifo: RTL and testbench
=================================

Name: acc_input_fifo

Overview:
- Input-side buffer that sits directly upstream of the double accumulator processor core and drives its ACCInput port.
- An external producer pushes 16-bit words through a valid/ready handshake.
- The block stores them in a first-word-fall-through FIFO and presents the head word on ACCInput.
- The core pulses rd_pop on the cycle it writes ACCInput into the register file (MemtoReg=3 with RegWrite), which consumes the head word.

Parameters:
- DEPTH, 8: number of 16-bit entries; must be a power of 2 and at least 2.
- EMPTY_VALUE, 16'h0000: value driven on ACCInput while the FIFO is empty.
- AW, log2(DEPTH): pointer width; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous active-low reset.
- wr_valid  input  1  producer has a word on wr_data.
- wr_data  input  16  word to push.
- wr_ready  output  1  FIFO can accept a word this cycle.
- rd_pop  input  1  core consumed the head word this cycle.
- ACCInput  output  16  head word, or EMPTY_VALUE when empty; connects to the core's ACCInput.
- in_empty  output  1  FIFO holds 0 entries.
- in_full  output  1  FIFO holds DEPTH entries.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- ovf_err  output  1  sticky: a push was attempted while full.
- unf_err  output  1  sticky: a pop was attempted while empty.
- clr_err  input  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (RST=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - in_empty=1, in_full=0, wr_ready=1, ACCInput=EMPTY_VALUE, ovf_err=0, unf_err=0.
  - Storage array is not reset.
  - Asserting reset mid-operation discards all contents immediately, with no wait for a clock edge.
- Push and pop acceptance:
  - wr_ready = !in_full. It depends on registered state only, with no combinational path from rd_pop.
  - Push is accepted when wr_valid && wr_ready: mem[wr_ptr] <= wr_data and wr_ptr increments.
  - Pop is accepted when rd_pop && !in_empty: rd_ptr increments.
  - Both pointers wrap modulo DEPTH, from DEPTH-1 to 0.
- Count and flags:
  - count +1 on push only, -1 on pop only, unchanged on simultaneous accepted push and pop.
  - in_empty = (count==0) and in_full = (count==DEPTH), both derived from registered count.
- Output timing:
  - ACCInput = mem[rd_ptr] when !in_empty, otherwise EMPTY_VALUE. It is a combinational read of registered state.
  - A word pushed into an empty FIFO appears on ACCInput the cycle after acceptance (1-cycle latency).
  - After a pop, the next word appears the cycle after the pop edge.
- Boundary conditions:
  - Full, with wr_valid=1 and rd_pop=1: the push is refused because wr_ready=0. The pop proceeds, and wr_ready rises next cycle. ovf_err is set because a push was attempted while full.
  - Empty, with wr_valid=1 and rd_pop=1: the pop is ignored and unf_err is set. The push is accepted, and count becomes 1 next cycle.
  - Overflow: wr_valid=1 while in_full=1 drops the data and sets ovf_err on the next edge. Contents and pointers are unchanged.
  - Underflow: rd_pop=1 while in_empty=1 leaves the pointers unchanged and sets unf_err on the next edge. ACCInput stays EMPTY_VALUE.
  - rd_pop held high for N cycles pops min(N, entries available). Each cycle is evaluated independently.
  - clr_err=1 clears both flags on the next edge. If a new error event occurs in the same cycle, the set wins and the flag stays 1.
  - wr_data is sampled only on accepted pushes. Its value while wr_valid=0 is don't-care.

Test Plan:
- Reset, then hold idle: in_empty=1, count=0, ACCInput=16'h0000, wr_ready=1, no error flags.
- Push 16'h1234, then 16'hABCD, on consecutive cycles with no pop: ACCInput=16'h1234 from the cycle after the first push and count=2. Pop once: ACCInput=16'hABCD next cycle and count=1.
- Push 8 words, 16'h0001..16'h0008, with a 9th push of 16'hFFFF while full: in_full=1, wr_ready=0, ovf_err=1. Popping 8 times yields 0001..0008 in order, and 16'hFFFF never appears.
- Fill to 5 entries, then hold wr_valid=1 and rd_pop=1 for 4 cycles: count stays 5 and the output order is preserved. Run further cycles until wr_ptr wraps past 7 to 0, and check the data is intact.
- Empty FIFO, pulse rd_pop: unf_err=1 and ACCInput=16'h0000. Then clr_err=1 for one cycle clears it; clr_err=1 together with rd_pop on an empty FIFO keeps unf_err=1.
- With 3 entries stored, drive RST=0 between clock edges: all outputs return to their reset values immediately. After release, push 16'h00AA and check it is the head word and count=1.

Source files
------------

// File: rtl/acc_input_fifo.sv
// ---------------------------------------------------------------------------
// acc_input_fifo
//
// Input-side buffer for the double accumulator core. A producer pushes 16-bit
// words via a valid/ready handshake; the block keeps them in a
// first-word-fall-through FIFO and presents the head word on ACCInput. The
// core pulses rd_pop on the cycle it writes ACCInput into its register file,
// which consumes the head word.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-low reset
//   wr_valid  in   producer has a word on wr_data
//   wr_data   in   [15:0] word to push
//   wr_ready  out  FIFO can accept a word this cycle (= !in_full)
//   rd_pop    in   core consumed the head word this cycle
//   ACCInput  out  [15:0] head word, or EMPTY_VALUE when empty
//   in_empty  out  FIFO holds 0 entries
//   in_full   out  FIFO holds DEPTH entries
//   count     out  [AW:0] number of stored entries
//   ovf_err   out  sticky: push attempted while full
//   unf_err   out  sticky: pop attempted while empty
//   clr_err   in   synchronous clear of both sticky flags (a new event wins)
// ---------------------------------------------------------------------------
module acc_input_fifo #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] EMPTY_VALUE = 16'h0000,
    localparam int         AW          = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_valid,
    input  logic [15:0]   wr_data,
    output logic          wr_ready,
    input  logic          rd_pop,
    output logic [15:0]   ACCInput,
    output logic          in_empty,
    output logic          in_full,
    output logic [AW:0]   count,
    output logic          ovf_err,
    output logic          unf_err,
    input  logic          clr_err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;

    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [15:0]   acc_s;

    // Flags and handshake derived only from registered count.
    always_comb begin
        empty_s = (count_q == {(AW+1){1'b0}});
        full_s  = (count_q == DEPTH_C);
        push_s  = wr_valid & ~full_s;
        pop_s   = rd_pop & ~empty_s;
    end

    // Next-state computation for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // A fresh error event takes priority over a same-cycle clear.
        if (wr_valid && full_s) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (rd_pop && empty_s) begin
            unf_d = 1'b1;
        end else if (clr_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; intentionally not reset, data is qualified by count.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head word falls through to the output; EMPTY_VALUE masks stale storage.
    always_comb begin
        if (empty_s) begin
            acc_s = EMPTY_VALUE;
        end else begin
            acc_s = mem_q[rd_ptr_q];
        end
    end

    assign ACCInput = acc_s;
    assign in_empty = empty_s;
    assign in_full  = full_s;
    assign wr_ready = ~full_s;
    assign count    = count_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;

endmodule

// File: tb/tb_acc_input_fifo.sv
// ---------------------------------------------------------------------------
// tb_acc_input_fifo
//
// Self-checking bench for acc_input_fifo (DEPTH=8, EMPTY_VALUE=0). A small
// reference model (queue of stored words plus sticky flags) predicts every
// output; popped words are compared against the queue head. A table of
// hand-computed vectors covers the basic handshake and error-flag cases, and
// hand-written sequences cover fill/overflow, sustained push+pop with pointer
// wrap, mid-cycle asynchronous reset and a random soak.
// ---------------------------------------------------------------------------
module tb_acc_input_fifo;

    localparam int DEPTH = 8;

    logic        CLK;
    logic        RST;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_pop;
    logic [15:0] ACCInput;
    logic        in_empty;
    logic        in_full;
    logic [3:0]  count;
    logic        ovf_err;
    logic        unf_err;
    logic        clr_err;

    acc_input_fifo #(.DEPTH(DEPTH), .EMPTY_VALUE(16'h0000)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_pop   (rd_pop),
        .ACCInput (ACCInput),
        .in_empty (in_empty),
        .in_full  (in_full),
        .count    (count),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err),
        .clr_err  (clr_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_unf;

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic        rp;
        logic        ce;
        logic [3:0]  e_count;
        logic [15:0] e_acc;
        logic        e_empty;
        logic        e_full;
        logic        e_ready;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic check_model(input string tag);
        logic [15:0] exp_acc;
        exp_acc = (mq.size() == 0) ? 16'h0000 : mq[0];
        chk({tag, ".count"},    32'(count),    32'(mq.size()));
        chk({tag, ".acc"},      32'(ACCInput), 32'(exp_acc));
        chk({tag, ".empty"},    32'(in_empty), 32'(mq.size() == 0));
        chk({tag, ".full"},     32'(in_full),  32'(mq.size() == DEPTH));
        chk({tag, ".ready"},    32'(wr_ready), 32'(mq.size() != DEPTH));
        chk({tag, ".ovf"},      32'(ovf_err),  32'(m_ovf));
        chk({tag, ".unf"},      32'(unf_err),  32'(m_unf));
    endtask

    // One clock cycle: drive inputs, check popped data, advance model, check.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic wv, input logic [15:0] wd, input logic rp,
                        input logic ce, input string tag);
        int  sz;
        logic do_push, do_pop, n_ovf, n_unf;
        wr_valid = wv;
        wr_data  = wd;
        rd_pop   = rp;
        clr_err  = ce;
        sz = mq.size();
        do_pop  = rp && (sz > 0);
        do_push = wv && (sz < DEPTH);
        if (do_pop) chk({tag, ".pop_data"}, 32'(ACCInput), 32'(mq[0]));
        n_ovf = (wv && sz == DEPTH) ? 1'b1 : (ce ? 1'b0 : m_ovf);
        n_unf = (rp && sz == 0)     ? 1'b1 : (ce ? 1'b0 : m_unf);
        @(posedge CLK);
        #1;
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(wd);
        m_ovf = n_ovf;
        m_unf = n_unf;
        check_model(tag);
        wr_valid = 1'b0;
        wr_data  = 16'hDEAD;
        rd_pop   = 1'b0;
        clr_err  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {wv, wd, rp, ce, count, acc, empty, full, ready, ovf, unf}
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 4'd1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 4'd2, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h5555, 1'b1, 1'b0, 4'd1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        RST      = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        rd_pop   = 1'b0;
        clr_err  = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        mq.delete();

        // Reset state while held in reset and after release
        repeat (2) @(posedge CLK);
        #1;
        check_model("reset_hold");
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_model("reset_idle");

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].wv, tbl[i].wd, tbl[i].rp, tbl[i].ce, $sformatf("vec%0d", i));
            chk($sformatf("tbl%0d.count", i), 32'(count),    32'(tbl[i].e_count));
            chk($sformatf("tbl%0d.acc", i),   32'(ACCInput), 32'(tbl[i].e_acc));
            chk($sformatf("tbl%0d.empty", i), 32'(in_empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.full", i),  32'(in_full),  32'(tbl[i].e_full));
            chk($sformatf("tbl%0d.ready", i), 32'(wr_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.ovf", i),   32'(ovf_err),  32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d.unf", i),   32'(unf_err),  32'(tbl[i].e_unf));
        end

        // Fill to full, push while full, drain in order
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 16'hFFFF, 1'b0, 1'b0, "push_full");
        chk("full_flag", 32'(in_full), 32'd1);
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_ovf", 32'(ovf_err), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", 32'(ACCInput), 32'(i));
            step(1'b0, 16'h0000, 1'b1, 1'b0, "drain");
        end
        chk("drain_empty", 32'(in_empty), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1, "clr_ovf");

        // Full with simultaneous push and pop: push refused, pop proceeds
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, "refill");
        step(1'b1, 16'hFFFF, 1'b1, 1'b0, "full_push_pop");
        chk("fpp_count", 32'(count), 32'd7);
        chk("fpp_ready", 32'(wr_ready), 32'd1);
        chk("fpp_ovf", 32'(ovf_err), 32'd1);
        while (mq.size() > 0) step(1'b0, 16'h0000, 1'b1, 1'b0, "drain2");
        step(1'b0, 16'h0000, 1'b0, 1'b1, "clr2");

        // Five entries, then sustained push+pop through pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, "fill5");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0B00 + 16'(i), 1'b1, 1'b0, "sustain");
            chk("sustain_count", 32'(count), 32'd5);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b1, 1'b0, "wrap");
        chk("wrap_count", 32'(count), 32'd5);
        while (mq.size() > 3) step(1'b0, 16'h0000, 1'b1, 1'b0, "trim");

        // Asynchronous reset between edges with 3 entries stored
        chk("pre_rst_count", 32'(count), 32'd3);
        #3;
        RST = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_model("async_rst");
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_model("post_rst");
        step(1'b1, 16'h00AA, 1'b0, 1'b0, "push_aa");
        chk("aa_head", 32'(ACCInput), 32'h00AA);
        chk("aa_count", 32'(count), 32'd1);

        // Random soak against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
